// File: rtl/rv32i_axil_sram_slave.sv
// AXI4-Lite slave in front of a word-organised SRAM with byte-strobe writes.
// One transaction at a time, optional read/write wait states, SLVERR outside the window.
module rv32i_axil_sram_slave #(
    parameter int unsigned MEM_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RD_WAIT   = 0,
    parameter int unsigned WR_WAIT   = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready
);

    localparam int unsigned IDX_W       = $clog2(MEM_WORDS);
    localparam logic [31:0] SPAN        = 32'(4 * MEM_WORDS);
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE, S_RD_WAIT, S_RD_RESP, S_WR_WAIT, S_WR_RESP
    } state_t;

    state_t      state_q;
    logic        aw_held_q, w_held_q;
    logic [31:0] awaddr_q, wdata_q, araddr_q;
    logic [3:0]  wstrb_q;
    logic [7:0]  cnt_q;
    logic        rvalid_q, bvalid_q;
    logic [31:0] rdata_q;
    logic [1:0]  rresp_q, bresp_q;

    logic [31:0] mem [MEM_WORDS];

    function automatic logic in_range(input logic [31:0] addr);
        return (addr - BASE_ADDR) < SPAN;
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] addr);
        return IDX_W'((addr - BASE_ADDR) >> 2);
    endfunction

    logic is_idle;
    logic ar_hs, aw_hs, w_hs, wr_go, wr_commit;
    logic [31:0] wr_addr, wr_data, rd_addr, rd_word;
    logic [3:0]  wr_strb;
    logic [1:0]  rd_resp, wr_resp;
    logic        unused_prot;

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    assign is_idle       = (state_q == S_IDLE);
    assign s_axi_arready = !rst && is_idle && !aw_held_q && !w_held_q;
    assign s_axi_awready = !rst && is_idle && !aw_held_q && (w_held_q || !s_axi_arvalid);
    assign s_axi_wready  = !rst && is_idle && !w_held_q && (aw_held_q || !s_axi_arvalid);

    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign wr_go = is_idle && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // Held halves take priority; once a write is past IDLE both flags are set, so this picks the latched copy.
    always_comb begin
        wr_addr = aw_held_q ? awaddr_q : s_axi_awaddr;
        wr_data = w_held_q ? wdata_q : s_axi_wdata;
        wr_strb = w_held_q ? wstrb_q : s_axi_wstrb;
        wr_resp = in_range(wr_addr) ? RESP_OKAY : RESP_SLVERR;
        rd_addr = is_idle ? s_axi_araddr : araddr_q;
        rd_resp = in_range(rd_addr) ? RESP_OKAY : RESP_SLVERR;
        rd_word = in_range(rd_addr) ? mem[word_idx(rd_addr)] : 32'h0;
    end

    assign wr_commit = !rst && ((wr_go && (WR_WAIT == 0)) ||
                                (state_q == S_WR_WAIT && cnt_q == 8'd1));

    always_ff @(posedge clk) begin
        if (wr_commit && in_range(wr_addr)) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_strb[b]) mem[word_idx(wr_addr)][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            cnt_q     <= 8'd0;
            rvalid_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rdata_q   <= 32'h0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (ar_hs) begin
                        araddr_q <= s_axi_araddr;
                        if (RD_WAIT == 0) begin
                            rdata_q  <= rd_word;
                            rresp_q  <= rd_resp;
                            rvalid_q <= 1'b1;
                            state_q  <= S_RD_RESP;
                        end else begin
                            cnt_q   <= 8'(RD_WAIT);
                            state_q <= S_RD_WAIT;
                        end
                    end else begin
                        if (aw_hs) begin
                            aw_held_q <= 1'b1;
                            awaddr_q  <= s_axi_awaddr;
                        end
                        if (w_hs) begin
                            w_held_q <= 1'b1;
                            wdata_q  <= s_axi_wdata;
                            wstrb_q  <= s_axi_wstrb;
                        end
                        if (wr_go) begin
                            if (WR_WAIT == 0) begin
                                bresp_q  <= wr_resp;
                                bvalid_q <= 1'b1;
                                state_q  <= S_WR_RESP;
                            end else begin
                                cnt_q   <= 8'(WR_WAIT);
                                state_q <= S_WR_WAIT;
                            end
                        end
                    end
                end
                S_RD_WAIT: begin
                    if (cnt_q == 8'd1) begin
                        rdata_q  <= rd_word;
                        rresp_q  <= rd_resp;
                        rvalid_q <= 1'b1;
                        state_q  <= S_RD_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_RD_RESP: begin
                    if (s_axi_rready) begin
                        rvalid_q <= 1'b0;
                        state_q  <= S_IDLE;
                    end
                end
                S_WR_WAIT: begin
                    if (cnt_q == 8'd1) begin
                        bresp_q  <= wr_resp;
                        bvalid_q <= 1'b1;
                        state_q  <= S_WR_RESP;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                S_WR_RESP: begin
                    if (s_axi_bready) begin
                        bvalid_q  <= 1'b0;
                        aw_held_q <= 1'b0;
                        w_held_q  <= 1'b0;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign s_axi_rvalid = rvalid_q;
    assign s_axi_rdata  = rdata_q;
    assign s_axi_rresp  = rresp_q;
    assign s_axi_bvalid = bvalid_q;
    assign s_axi_bresp  = bresp_q;

endmodule

// File: tb/tb_rv32i_axil_sram_slave.sv
// Bench for rv32i_axil_sram_slave: a zero-wait instance and a wait-state instance,
// directed vector table, hand-written corner sequences and randomized traffic vs a word-array model.
module tb_rv32i_axil_sram_slave;

    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          WORDS = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [31:0] awaddr [2], wdata [2], araddr [2], rdata [2];
    logic [3:0]  wstrb [2];
    logic [1:0]  bresp [2], rresp [2];
    logic        awvalid [2], awready [2], wvalid [2], wready [2];
    logic        bvalid [2], bready [2], arvalid [2], arready [2];
    logic        rvalid [2], rready [2];
    logic [2:0]  prot = 3'b010;

    rv32i_axil_sram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .RD_WAIT(0), .WR_WAIT(0)) dut0 (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr[0]), .s_axi_awprot(prot), .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
        .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]), .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]),
        .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
        .s_axi_araddr(araddr[0]), .s_axi_arprot(prot), .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]),
        .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0])
    );

    rv32i_axil_sram_slave #(.MEM_WORDS(WORDS), .BASE_ADDR(BASE), .RD_WAIT(3), .WR_WAIT(2)) dut1 (
        .clk(clk), .rst(rst),
        .s_axi_awaddr(awaddr[1]), .s_axi_awprot(prot), .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
        .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]), .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]),
        .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
        .s_axi_araddr(araddr[1]), .s_axi_arprot(prot), .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]),
        .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1])
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl [2][WORDS];

    function automatic int rw(int d);
        return (d == 1) ? 3 : 0;
    endfunction

    function automatic int ww(int d);
        return (d == 1) ? 2 : 0;
    endfunction

    function automatic bit in_win(logic [31:0] a);
        return (a - BASE) < 32'(4 * WORDS);
    endfunction

    function automatic logic [1:0] exp_resp(logic [31:0] a);
        return in_win(a) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] exp_read(int d, logic [31:0] a);
        if (!in_win(a)) return 32'h0;
        return mdl[d][(a - BASE) / 4];
    endfunction

    task automatic model_write(int d, logic [31:0] a, logic [31:0] dat, logic [3:0] st);
        logic [31:0] mask;
        if (!in_win(a)) return;
        mask = 32'h0;
        for (int b = 0; b < 4; b++) if (st[b]) mask = mask | (32'hFF << (8 * b));
        mdl[d][(a - BASE) / 4] = (mdl[d][(a - BASE) / 4] & ~mask) | (dat & mask);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: handshake never happened (t=%0t)", name, $time);
    endtask

    task automatic do_write(int d, logic [31:0] a, logic [31:0] dat, logic [3:0] st,
                            int aw_dly, int w_dly, int b_dly, logic [1:0] er);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int cyc = 0;
        while (!(aw_done && w_done)) begin
            @(negedge clk);
            awvalid[d] = !aw_done && (cyc >= aw_dly);
            awaddr[d]  = a;
            wvalid[d]  = !w_done && (cyc >= w_dly);
            wdata[d]   = dat;
            wstrb[d]   = st;
            #1;
            if (w_done && !aw_done) chk("wready_after_w", wready[d], 0);
            if (aw_done && !w_done) chk("awready_after_aw", awready[d], 0);
            aw_hs = awvalid[d] && awready[d];
            w_hs  = wvalid[d] && wready[d];
            @(posedge clk);
            aw_done = aw_done || aw_hs;
            w_done  = w_done || w_hs;
            cyc++;
            if (cyc > 100) begin
                timeout("write_handshake");
                break;
            end
        end
        @(negedge clk);
        awvalid[d] = 1'b0;
        wvalid[d]  = 1'b0;
        for (int k = 0; k <= ww(d); k++) begin
            if (k > 0) @(negedge clk);
            chk((k == ww(d)) ? "bvalid_on_time" : "bvalid_early", bvalid[d], (k == ww(d)));
        end
        chk("bresp", bresp[d], er);
        for (int k = 0; k < b_dly; k++) begin
            @(negedge clk);
            chk("bvalid_hold", bvalid[d], 1);
            chk("bresp_hold", bresp[d], er);
        end
        bready[d] = 1'b1;
        @(negedge clk);
        bready[d] = 1'b0;
        chk("bvalid_single_pulse", bvalid[d], 0);
    endtask

    task automatic do_read(int d, logic [31:0] a, int r_dly, logic [31:0] ed, logic [1:0] er);
        int cyc = 0;
        @(negedge clk);
        arvalid[d] = 1'b1;
        araddr[d]  = a;
        #1;
        while (!arready[d] && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        if (!arready[d]) begin
            timeout("read_handshake");
            arvalid[d] = 1'b0;
            return;
        end
        @(posedge clk);
        @(negedge clk);
        arvalid[d] = 1'b0;
        for (int k = 0; k <= rw(d); k++) begin
            if (k > 0) @(negedge clk);
            chk((k == rw(d)) ? "rvalid_on_time" : "rvalid_early", rvalid[d], (k == rw(d)));
        end
        chk("rdata", rdata[d], ed);
        chk("rresp", rresp[d], er);
        for (int k = 0; k < r_dly; k++) begin
            @(negedge clk);
            chk("rvalid_hold", rvalid[d], 1);
            chk("rdata_hold", rdata[d], ed);
        end
        rready[d] = 1'b1;
        @(negedge clk);
        rready[d] = 1'b0;
        chk("rvalid_single_pulse", rvalid[d], 0);
    endtask

    typedef struct {
        int          d;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        int          aw_dly;
        int          w_dly;
        int          rdy_dly;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t tbl [18];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] a, dat, old;
        logic [3:0]  st;
        int          d, cyc;

        tbl[0]  = '{0, 1'b1, 32'h1010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 32'h0, 2'b00};
        tbl[1]  = '{0, 1'b0, 32'h1010, 32'h0, 4'h0, 0, 0, 0, 32'hDEADBEEF, 2'b00};
        tbl[2]  = '{0, 1'b1, 32'h1014, 32'h11223344, 4'hF, 0, 0, 0, 32'h0, 2'b00};
        tbl[3]  = '{0, 1'b1, 32'h1014, 32'hAABBCCDD, 4'b0101, 0, 0, 0, 32'h0, 2'b00};
        tbl[4]  = '{0, 1'b0, 32'h1014, 32'h0, 4'h0, 0, 0, 0, 32'h11BB33DD, 2'b00};
        tbl[5]  = '{0, 1'b1, 32'h1018, 32'hCAFEF00D, 4'hF, 3, 0, 2, 32'h0, 2'b00};
        tbl[6]  = '{0, 1'b0, 32'h101B, 32'h0, 4'h0, 0, 0, 1, 32'hCAFEF00D, 2'b00};
        tbl[7]  = '{0, 1'b1, 32'h1000, 32'h01020304, 4'hF, 0, 2, 0, 32'h0, 2'b00};
        tbl[8]  = '{0, 1'b1, 32'h1040, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 32'h0, 2'b10};
        tbl[9]  = '{0, 1'b0, 32'h1040, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b10};
        tbl[10] = '{0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 0, 0, 32'h01020304, 2'b00};
        tbl[11] = '{0, 1'b1, 32'h0FFC, 32'h55555555, 4'hF, 0, 0, 0, 32'h0, 2'b10};
        tbl[12] = '{0, 1'b1, 32'h1000, 32'h12345678, 4'h0, 0, 0, 0, 32'h0, 2'b00};
        tbl[13] = '{0, 1'b0, 32'h1000, 32'h0, 4'h0, 0, 0, 0, 32'h01020304, 2'b00};
        tbl[14] = '{1, 1'b1, 32'h1020, 32'hA5A5A5A5, 4'hF, 0, 2, 4, 32'h0, 2'b00};
        tbl[15] = '{1, 1'b0, 32'h1020, 32'h0, 4'h0, 0, 0, 4, 32'hA5A5A5A5, 2'b00};
        tbl[16] = '{1, 1'b1, 32'h103C, 32'h76543210, 4'hF, 1, 0, 0, 32'h0, 2'b00};
        tbl[17] = '{1, 1'b0, 32'h1044, 32'h0, 4'h0, 0, 0, 0, 32'h0, 2'b10};

        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            awvalid[i] = 0; wvalid[i] = 0; bready[i] = 0; arvalid[i] = 0; rready[i] = 0;
            awaddr[i] = 0; wdata[i] = 0; wstrb[i] = 0; araddr[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk("rst_arready", arready[i], 0);
            chk("rst_awready", awready[i], 0);
            chk("rst_wready", wready[i], 0);
            chk("rst_rvalid", rvalid[i], 0);
            chk("rst_bvalid", bvalid[i], 0);
            chk("rst_rdata", rdata[i], 0);
            chk("rst_rresp", rresp[i], 0);
            chk("rst_bresp", bresp[i], 0);
        end
        rst = 1'b0;
        #1;
        chk("idle_arready", arready[0], 1);
        chk("idle_awready", awready[1], 1);

        for (int i = 0; i < 2; i++) begin
            for (int w = 0; w < WORDS; w++) begin
                dat = $urandom;
                a = BASE + 32'(4 * w);
                do_write(i, a, dat, 4'hF, 0, 0, 0, 2'b00);
                model_write(i, a, dat, 4'hF);
            end
        end

        foreach (tbl[i]) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].d, tbl[i].addr, tbl[i].data, tbl[i].strb,
                         tbl[i].aw_dly, tbl[i].w_dly, tbl[i].rdy_dly, tbl[i].exp_resp);
                model_write(tbl[i].d, tbl[i].addr, tbl[i].data, tbl[i].strb);
            end else begin
                do_read(tbl[i].d, tbl[i].addr, tbl[i].rdy_dly, tbl[i].exp_data, tbl[i].exp_resp);
            end
        end

        // Simultaneous AR and AW+W: the read wins and sees the old word.
        a = 32'h1024;
        old = exp_read(0, a);
        @(negedge clk);
        arvalid[0] = 1; araddr[0] = a;
        awvalid[0] = 1; awaddr[0] = a;
        wvalid[0] = 1;  wdata[0] = 32'h0BADF00D; wstrb[0] = 4'hF;
        #1;
        chk("race_arready", arready[0], 1);
        chk("race_awready", awready[0], 0);
        chk("race_wready", wready[0], 0);
        @(posedge clk);
        @(negedge clk);
        arvalid[0] = 0;
        #1;
        chk("race_awready_in_rresp", awready[0], 0);
        chk("race_rvalid", rvalid[0], 1);
        chk("race_rdata_old", rdata[0], old);
        rready[0] = 1;
        @(negedge clk);
        rready[0] = 0;
        #1;
        chk("race_rvalid_clear", rvalid[0], 0);
        chk("race_awready_after", awready[0], 1);
        chk("race_wready_after", wready[0], 1);
        @(negedge clk);
        awvalid[0] = 0; wvalid[0] = 0;
        chk("race_bvalid", bvalid[0], 1);
        chk("race_bresp", bresp[0], 0);
        bready[0] = 1;
        @(negedge clk);
        bready[0] = 0;
        chk("race_bvalid_clear", bvalid[0], 0);
        model_write(0, a, 32'h0BADF00D, 4'hF);
        do_read(0, a, 0, exp_read(0, a), 2'b00);

        // Reset during the read wait: the response must never appear.
        @(negedge clk);
        arvalid[1] = 1; araddr[1] = 32'h1020;
        #1;
        chk("rstwait_arready", arready[1], 1);
        @(posedge clk);
        @(negedge clk);
        arvalid[1] = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("rstwait_arready_in_rst", arready[0], 0);
        @(negedge clk);
        rst = 0;
        cyc = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rvalid[1]) cyc++;
        end
        chk("rstwait_no_rvalid", 32'(cyc), 0);
        do_read(1, 32'h1020, 0, exp_read(1, 32'h1020), 2'b00);

        for (int n = 0; n < 80; n++) begin
            d = $urandom_range(0, 1);
            a = BASE + 32'(4 * $urandom_range(0, WORDS + 1)) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = 32'h0000_0FF0;
            if ($urandom_range(0, 1) == 1) begin
                dat = $urandom;
                st = 4'($urandom_range(0, 15));
                do_write(d, a, dat, st, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), exp_resp(a));
                model_write(d, a, dat, st);
            end else begin
                do_read(d, a, $urandom_range(0, 3), exp_read(d, a), exp_resp(a));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
